// File: rtl/fp16_to_fixed.sv
// rtl/fp16_to_fixed.sv - FP16 to signed Q(INT_W.FRAC_W) converter, one shift per cycle
module fp16_to_fixed #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [15:0]               fp_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [INT_W+FRAC_W-1:0]   fix_o,
  output logic                      ovf_o,
  output logic                      inv_o
);

  localparam int OUT_W = INT_W + FRAC_W;
  localparam logic [OUT_W-1:0] L_POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] L_NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [7:0] L_PK_MAX  = 8'(OUT_W - 2);
  localparam logic signed [7:0] L_PK_EDGE = 8'(OUT_W - 1);
  localparam logic signed [7:0] L_FRAC    = 8'(FRAC_W);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [OUT_W-1:0] r_mag;
  logic [5:0]       r_cnt;
  logic             r_left;
  logic             r_sign;

  logic             w_sign;
  logic [4:0]       w_exp;
  logic [9:0]       w_frac;
  logic [10:0]      w_mant;
  logic [3:0]       w_p;
  logic signed [7:0] w_e;
  logic signed [7:0] w_k;
  logic signed [7:0] w_kneg;
  logic signed [7:0] w_pk;
  logic [5:0]       w_cnt0;
  logic             w_zero;
  logic             w_nan;
  logic             w_inf;
  logic             w_pow2;
  logic             w_big;
  logic             w_min_exact;
  logic             w_special;
  logic             w_accept;

  assign w_sign   = fp_i[15];
  assign w_exp    = fp_i[14:10];
  assign w_frac   = fp_i[9:0];
  assign w_accept = in_valid_i && (r_state == S_IDLE);

  assign in_ready_o  = (r_state == S_IDLE);
  assign out_valid_o = (r_state == S_DONE);

  // Decode the operand: mantissa, leading-one index, shift amount and special cases
  always_comb begin
    w_mant = (w_exp == 5'd0) ? {1'b0, w_frac} : {1'b1, w_frac};
    w_p = 4'd0;
    for (int i = 0; i < 11; i++) begin
      if (w_mant[i]) w_p = 4'(i);
    end
    w_e    = (w_exp == 5'd0) ? -8'sd14 : ($signed({3'b000, w_exp}) - 8'sd15);
    w_k    = w_e - 8'sd10 + L_FRAC;
    w_kneg = -w_k;
    w_pk   = $signed({4'b0000, w_p}) + w_k;
    // Right shifts past the mantissa width all yield zero, so cap the loop length
    if (w_k < 0) w_cnt0 = (w_kneg > 8'sd11) ? 6'd11 : w_kneg[5:0];
    else         w_cnt0 = w_k[5:0];
    w_zero      = (w_exp == 5'd0) && (w_frac == 10'd0);
    w_nan       = (w_exp == 5'd31) && (w_frac != 10'd0);
    w_inf       = (w_exp == 5'd31) && (w_frac == 10'd0);
    w_pow2      = ((w_mant & (w_mant - 11'd1)) == 11'd0);
    w_big       = (w_pk > L_PK_MAX);
    // -2^(OUT_W-1) is representable even though its magnitude is not
    w_min_exact = w_sign && w_pow2 && (w_pk == L_PK_EDGE);
    w_special   = w_zero || w_nan || w_inf || w_big;
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_special ? S_DONE : S_SHIFT;
      S_SHIFT: if (r_cnt == 6'd0) w_next = S_DONE;
      S_DONE:  if (out_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: load on accept, shift while counting down, write the signed result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mag  <= '0;
      r_cnt  <= '0;
      r_left <= 1'b0;
      r_sign <= 1'b0;
      fix_o  <= '0;
      ovf_o  <= 1'b0;
      inv_o  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            ovf_o  <= 1'b0;
            inv_o  <= 1'b0;
            r_sign <= w_sign;
            if (w_nan) begin
              fix_o <= '0;
              inv_o <= 1'b1;
            end else if (w_zero) begin
              fix_o <= '0;
            end else if (w_min_exact) begin
              fix_o <= L_NEG_MIN;
            end else if (w_inf || w_big) begin
              fix_o <= w_sign ? L_NEG_MIN : L_POS_MAX;
              ovf_o <= 1'b1;
            end else begin
              r_mag  <= OUT_W'(w_mant);
              r_cnt  <= w_cnt0;
              r_left <= (w_k > 0);
            end
          end
        end
        S_SHIFT: begin
          if (r_cnt != 6'd0) begin
            r_mag <= r_left ? (r_mag << 1) : (r_mag >> 1);
            r_cnt <= r_cnt - 6'd1;
          end else begin
            fix_o <= r_sign ? (-r_mag) : r_mag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_to_fixed.sv
// tb/tb_fp16_to_fixed.sv - self-checking bench for fp16_to_fixed
module tb_fp16_to_fixed;

  localparam int INT_W  = 16;
  localparam int FRAC_W = 8;
  localparam int OUT_W  = INT_W + FRAC_W;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [15:0]      fp_i = 16'h0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b1;
  logic [OUT_W-1:0] fix_o;
  logic             ovf_o;
  logic             inv_o;

  fp16_to_fixed #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .fp_i(fp_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .fix_o(fix_o), .ovf_o(ovf_o), .inv_o(inv_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc = 0;

  typedef struct {
    logic [15:0]      fp;
    logic [OUT_W-1:0] fix;
    logic             ovf;
    logic             inv;
    int               due;
    bit               seen;
    bit               late;
  } exp_t;

  exp_t q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  // Reference: real value of the FP16 operand scaled by 2^FRAC_W, truncated and saturated
  function automatic void model(input logic [15:0] fp, output logic [OUT_W-1:0] fix,
                                output logic ovf, output logic inv, output int lat);
    int  ex = int'(fp[14:10]);
    int  fr = int'(fp[9:0]);
    int  e, m, k, ak;
    real scaled, lim;
    lim = pow2(OUT_W - 1);
    fix = '0; ovf = 1'b0; inv = 1'b0; lat = 1;
    if (ex == 31) begin
      if (fr != 0) inv = 1'b1;
      else begin
        fix = fp[15] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        ovf = 1'b1;
      end
      return;
    end
    if (ex == 0 && fr == 0) return;
    e = (ex == 0) ? -14 : ex - 15;
    m = (ex == 0) ? fr : 1024 + fr;
    scaled = real'(m) * pow2(e - 10 + FRAC_W);
    if (fp[15]) scaled = -scaled;
    if (scaled >= lim) begin
      fix = {1'b0, {(OUT_W-1){1'b1}}}; ovf = 1'b1;
    end else if (scaled < -lim) begin
      fix = {1'b1, {(OUT_W-1){1'b0}}}; ovf = 1'b1;
    end else if (scaled == -lim) begin
      fix = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      fix = OUT_W'($rtoi(scaled));
      k  = e - 10 + FRAC_W;
      ak = (k < 0) ? -k : k;
      if (k < 0 && ak > 11) ak = 11;
      lat = 2 + ak;
    end
  endfunction

  // Compare process: tracks accepts and checks every valid output cycle against the model
  always @(negedge clk_i) begin
    exp_t x;
    int   lat;
    if (rst_i) begin
      q.delete();
    end else begin
      if (out_valid_o) begin
        if (q.size() == 0) begin
          check("spurious_valid", 32'(out_valid_o), 32'd0);
        end else begin
          if (!q[0].seen) begin
            check($sformatf("latency_%h", q[0].fp), 32'(cyc), 32'(q[0].due));
            q[0].seen = 1'b1;
          end
          check($sformatf("fix_%h", q[0].fp), 32'(fix_o), 32'(q[0].fix));
          check($sformatf("ovf_%h", q[0].fp), 32'(ovf_o), 32'(q[0].ovf));
          check($sformatf("inv_%h", q[0].fp), 32'(inv_o), 32'(q[0].inv));
          check("ready_low_in_done", 32'(in_ready_o), 32'd0);
          if (out_ready_i) void'(q.pop_front());
        end
      end else if (q.size() != 0 && !q[0].seen && !q[0].late && cyc >= q[0].due) begin
        q[0].late = 1'b1;
        check($sformatf("late_valid_%h", q[0].fp), 32'(out_valid_o), 32'd1);
      end
      if (in_valid_i && in_ready_o) begin
        x.fp = fp_i;
        model(fp_i, x.fix, x.ovf, x.inv, lat);
        x.due = cyc + lat;
        x.seen = 1'b0;
        x.late = 1'b0;
        q.push_back(x);
        n_acc++;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready_o && n < 100) begin
      @(posedge clk_i); #2; n++;
    end
    if (!in_ready_o) check("wait_ready_timeout", 32'(in_ready_o), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !in_ready_o) && n < 100) begin
      @(posedge clk_i); #2; n++;
    end
    if (q.size() != 0) check("wait_idle_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic send(input logic [15:0] fp);
    wait_ready();
    in_valid_i = 1'b1;
    fp_i = fp;
    @(posedge clk_i); #2;
    in_valid_i = 1'b0;
  endtask

  logic [15:0] vec [0:17] = '{
    16'h3C00, 16'hC100, 16'h7BFF, 16'hFC00, 16'h7E00, 16'h8000, 16'h0001,
    16'h4400, 16'hB400, 16'h1C00, 16'h8001, 16'h0400, 16'h77FF, 16'hF7FF,
    16'h7800, 16'hF800, 16'h7C00, 16'hFE01
  };

  initial begin
    logic [OUT_W-1:0] mf;
    logic mo, mi;
    int ml, acc0, n;

    mf = '0; mo = 1'b0; mi = 1'b0; ml = 0;
    model(16'h3C00, mf, mo, mi, ml);
    check("pin_3C00_fix", 32'(mf), 32'h000100); check("pin_3C00_lat", 32'(ml), 32'd4);
    model(16'hC100, mf, mo, mi, ml);
    check("pin_C100_fix", 32'(mf), 32'hFFFD80); check("pin_C100_lat", 32'(ml), 32'd3);
    model(16'h7BFF, mf, mo, mi, ml);
    check("pin_7BFF_fix", 32'(mf), 32'h7FFFFF); check("pin_7BFF_ovf", 32'(mo), 32'd1);
    model(16'h0001, mf, mo, mi, ml);
    check("pin_0001_fix", 32'(mf), 32'h0); check("pin_0001_lat", 32'(ml), 32'd13);
    model(16'hF800, mf, mo, mi, ml);
    check("pin_F800_fix", 32'(mf), 32'h800000); check("pin_F800_ovf", 32'(mo), 32'd0);
    model(16'h77FF, mf, mo, mi, ml);
    check("pin_77FF_fix", 32'(mf), 32'h7FF000); check("pin_77FF_lat", 32'(ml), 32'd14);

    repeat (3) @(posedge clk_i);
    #2;
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_fix", 32'(fix_o), 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    check("rst_inv", 32'(inv_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #2;

    for (int i = 0; i < 18; i++) begin
      send(vec[i]);
      wait_idle();
    end

    // Backpressure with a competing operand held on the input
    out_ready_i = 1'b0;
    acc0 = n_acc;
    send(16'h4800);
    n = 0;
    while (!out_valid_o && n < 20) begin
      @(posedge clk_i); #2; n++;
    end
    check("bp_valid_seen", 32'(out_valid_o), 32'd1);
    in_valid_i = 1'b1;
    fp_i = 16'h3C00;
    repeat (5) begin
      @(posedge clk_i); #2;
    end
    check("bp_no_accept", 32'(n_acc - acc0), 32'd1);
    check("bp_fix_held", 32'(fix_o), 32'h000800);
    out_ready_i = 1'b1;
    @(posedge clk_i); #2;
    check("bp_idle_after_hs", 32'(in_ready_o), 32'd1);
    @(posedge clk_i); #2;
    in_valid_i = 1'b0;
    check("bp_accept_after_hs", 32'(n_acc - acc0), 32'd2);
    wait_idle();

    // Asynchronous reset in the middle of a long conversion
    send(16'hFC00);
    wait_idle();
    send(16'h0001);
    repeat (3) @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    check("arst_in_ready", 32'(in_ready_o), 32'd1);
    check("arst_out_valid", 32'(out_valid_o), 32'd0);
    check("arst_fix", 32'(fix_o), 32'd0);
    check("arst_ovf", 32'(ovf_o), 32'd0);
    check("arst_inv", 32'(inv_o), 32'd0);
    #2 rst_i = 1'b0;
    repeat (15) @(posedge clk_i);
    #2;
    check("arst_no_output", 32'(out_valid_o), 32'd0);
    send(16'h3C00);
    wait_idle();
    check("arst_recover_fix", 32'(fix_o), 32'h000100);

    repeat (3) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
